router3_grant_ctrl: RTL

ROUTER3_GRANT_CTRL -- requirements
Module: router3_grant_ctrl

---
 rtl/router3_grant_ctrl_if.sv | 40 ++++
 rtl/router3_grant_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/router3_grant_ctrl_if.sv
// Request/flit/tail inputs and grant/busy/err outputs for the
// three-output router grant controller.
interface router3_grant_ctrl_if;
    logic [1:0] req_p;
    logic [1:0] req_c1;
    logic [1:0] req_c2;
    logic       flit_p;
    logic       flit_c1;
    logic       flit_c2;
    logic       tail_p;
    logic       tail_c1;
    logic       tail_c2;
    logic [1:0] grant_p;
    logic [1:0] grant_c1;
    logic [1:0] grant_c2;
    logic       busy_p;
    logic       busy_c1;
    logic       busy_c2;
    logic       err_p;
    logic       err_c1;
    logic       err_c2;

    modport master (
        output req_p, req_c1, req_c2,
        output flit_p, flit_c1, flit_c2,
        output tail_p, tail_c1, tail_c2,
        input  grant_p, grant_c1, grant_c2,
        input  busy_p, busy_c1, busy_c2,
        input  err_p, err_c1, err_c2
    );

    modport slave (
        input  req_p, req_c1, req_c2,
        input  flit_p, flit_c1, flit_c2,
        input  tail_p, tail_c1, tail_c2,
        output grant_p, grant_c1, grant_c2,
        output busy_p, busy_c1, busy_c2,
        output err_p, err_c1, err_c2
    );
endinterface

// File: rtl/router3_grant_ctrl.sv
// Three independent two-source round-robin packet arbiters with
// a per-slice idle watchdog and sticky error flag.
module router3_grant_slice #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] req,
    input  logic       flit,
    input  logic       tail,
    output logic [1:0] grant,
    output logic       busy,
    output logic       err
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

    state_t        state, state_nx;
    logic          ptr, ptr_nx;
    logic [TW-1:0] cnt, cnt_nx;
    logic          err_nx;
    logic          cur, oth, expire;

    assign cur    = (state == GNT1);
    assign oth    = ~cur;
    assign expire = (TIMEOUT != 0) && (cnt == TMO);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            ptr   <= 1'b0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            cnt   <= cnt_nx;
            err   <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        err_nx   = err;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (req == 2'b01)
                    state_nx = GNT0;
                else if (req == 2'b10)
                    state_nx = GNT1;
                else if (req == 2'b11)
                    state_nx = ptr ? GNT1 : GNT0;
            end
            GNT0, GNT1: begin
                // A tail beats a same-cycle watchdog expiry.
                if (flit && tail) begin
                    ptr_nx = oth;
                    cnt_nx = '0;
                    if (req[oth])
                        state_nx = oth ? GNT1 : GNT0;
                    else if (!req[cur])
                        state_nx = IDLE;
                end else if (expire) begin
                    state_nx = IDLE;
                    ptr_nx   = oth;
                    cnt_nx   = '0;
                    err_nx   = 1'b1;
                end else if (flit) begin
                    cnt_nx = '0;
                end else if (cnt != '1) begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign grant = state;
    assign busy  = (state != IDLE);
endmodule

module router3_grant_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    router3_grant_ctrl_if.slave  bus
);
    router3_grant_slice #(.TIMEOUT(TIMEOUT), .TW(TW)) u_p (
        .CLK   (CLK),
        .RESET (RESET),
        .req   (bus.req_p),
        .flit  (bus.flit_p),
        .tail  (bus.tail_p),
        .grant (bus.grant_p),
        .busy  (bus.busy_p),
        .err   (bus.err_p)
    );

    router3_grant_slice #(.TIMEOUT(TIMEOUT), .TW(TW)) u_c1 (
        .CLK   (CLK),
        .RESET (RESET),
        .req   (bus.req_c1),
        .flit  (bus.flit_c1),
        .tail  (bus.tail_c1),
        .grant (bus.grant_c1),
        .busy  (bus.busy_c1),
        .err   (bus.err_c1)
    );

    router3_grant_slice #(.TIMEOUT(TIMEOUT), .TW(TW)) u_c2 (
        .CLK   (CLK),
        .RESET (RESET),
        .req   (bus.req_c2),
        .flit  (bus.flit_c2),
        .tail  (bus.tail_c2),
        .grant (bus.grant_c2),
        .busy  (bus.busy_c2),
        .err   (bus.err_c2)
    );
endmodule
